// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between two requesting cores, the arbiter and the shared external memory port.
// master drives requests, hold and memory read data; slave is the arbiter side.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 6
) ();
  logic          hold;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic          gnt0;
  logic          rsp0_valid;
  logic [AW-1:0] rsp0_data;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic          gnt1;
  logic          rsp1_valid;
  logic [AW-1:0] rsp1_data;
  logic [AW-1:0] ext_addr;
  logic          ext_rd;
  logic [AW-1:0] ext_data;
  logic          busy;

  modport master (
    output hold, req0_valid, req0_addr, req1_valid, req1_addr, ext_data,
    input  gnt0, rsp0_valid, rsp0_data, gnt1, rsp1_valid, rsp1_data, ext_addr, ext_rd, busy
  );

  modport slave (
    input  hold, req0_valid, req0_addr, req1_valid, req1_addr, ext_data,
    output gnt0, rsp0_valid, rsp0_data, gnt1, rsp1_valid, rsp1_data, ext_addr, ext_rd, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one pipelined external read port between two cores.
// Each issued read carries an owner tag down a LAT+1 deep pipeline to route its response.
module mem_port_arbiter #(
  parameter int unsigned AW  = 6,
  parameter int unsigned LAT = 1
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  logic          rr_q, rr_d;
  logic          gnt0, gnt1, granted;
  logic [AW-1:0] gnt_addr;

  logic [LAT:0]  tag_valid_q, tag_valid_d;
  logic [LAT:0]  tag_owner_q, tag_owner_d;
  logic          head_valid, head_owner;

  logic          ext_rd_q, ext_rd_d;
  logic [AW-1:0] ext_addr_q, ext_addr_d;

  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [AW-1:0] rsp0_data_q, rsp0_data_d;
  logic [AW-1:0] rsp1_data_q, rsp1_data_d;

  // Grant is combinational so a requester can complete its transfer in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !bus.hold) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = ~rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign granted  = gnt0 | gnt1;
  assign gnt_addr = gnt1 ? bus.req1_addr : bus.req0_addr;

  always_comb begin
    rr_d = rr_q;
    if (granted) begin
      rr_d = ~gnt1;
    end
  end

  always_comb begin
    ext_rd_d   = granted;
    ext_addr_d = granted ? gnt_addr : ext_addr_q;
  end

  // Stage 0 is the read on the bus this cycle; stage LAT lines up with ext_data.
  always_comb begin
    tag_valid_d = {tag_valid_q[LAT-1:0], granted};
    tag_owner_d = {tag_owner_q[LAT-1:0], gnt1};
  end

  assign head_valid = tag_valid_q[LAT];
  assign head_owner = tag_owner_q[LAT];

  always_comb begin
    rsp0_valid_d = head_valid & ~head_owner;
    rsp1_valid_d = head_valid & head_owner;
    rsp0_data_d  = rsp0_valid_d ? bus.ext_data : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? bus.ext_data : rsp1_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q         <= 1'b0;
      tag_valid_q  <= '0;
      tag_owner_q  <= '0;
      ext_rd_q     <= 1'b0;
      ext_addr_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rr_q         <= rr_d;
      tag_valid_q  <= tag_valid_d;
      tag_owner_q  <= tag_owner_d;
      ext_rd_q     <= ext_rd_d;
      ext_addr_q   <= ext_addr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign bus.gnt0       = gnt0;
  assign bus.gnt1       = gnt1;
  assign bus.ext_rd     = ext_rd_q;
  assign bus.ext_addr   = ext_addr_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.busy       = (|tag_valid_q) | rsp0_valid_q | rsp1_valid_q;

endmodule
